data_mem_ctrl: RTL and testbench

Single-cycle-access controller that shares the byte-addressed, little-endian data memory between two word requesters (port A: CPU load/store; port B: debug/DMA) and sequences the power-on fill of the memory. The controller owns every memory control signal (MemAddress, MemWriteData, MemWrite, MemRead). The memory's own Startin input is tied low; the fill is performed here as ordinary word writes. The block sits between the datapath's load/store unit and the data memory.

---
 rtl/data_mem_pkg.sv | 14 +
 rtl/rr_arbiter2.sv | 38 +++
 rtl/data_mem_ctrl.sv | 129 ++++++++++++
 tb/tb_data_mem_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data memory controller.
package data_mem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: the port that did not win last time wins a tie.
module rr_arbiter2
  import data_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_gnt;

  // One-hot grant; a tie goes to the port not recorded in last_gnt.
  always_comb begin
    gnt = '0;
    if (en) begin
      if (req[PORT_A] && req[PORT_B]) begin
        if (last_gnt == PORT_B) gnt[PORT_A] = 1'b1;
        else                    gnt[PORT_B] = 1'b1;
      end else begin
        gnt = req;
      end
    end
  end

  // Remember the winner only when a grant is actually issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt <= PORT_B;
    end else if (gnt[PORT_A]) begin
      last_gnt <= PORT_A;
    end else if (gnt[PORT_B]) begin
      last_gnt <= PORT_B;
    end
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: arbitrates two word ports and runs the power-on fill.
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES  = 44,
  parameter logic [31:0] FILL_VALUE = 32'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Start,
  output logic        Busy,
  input  logic        AReq,
  input  logic        AWe,
  input  logic [31:0] AAddr,
  input  logic [31:0] AWData,
  output logic        AGnt,
  output logic [31:0] ARData,
  output logic        AValid,
  output logic        AErr,
  input  logic        BReq,
  input  logic        BWe,
  input  logic [31:0] BAddr,
  input  logic [31:0] BWData,
  output logic        BGnt,
  output logic [31:0] BRData,
  output logic        BValid,
  output logic        BErr,
  output logic [31:0] MemAddress,
  output logic [31:0] MemWriteData,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [31:0] MemReadData
);

  localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES - WORD_BYTES);

  state_t      state, state_next;
  logic [31:0] fill_ptr, fill_ptr_next;
  logic [1:0]  gnt;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        legal;

  rr_arbiter2 u_arb (
    .clk (clk),
    .rst (rst),
    .en  (state == IDLE),
    .req ({BReq, AReq}),
    .gnt (gnt)
  );

  assign AGnt = gnt[PORT_A];
  assign BGnt = gnt[PORT_B];

  // Select the granted port's access and check its legality.
  always_comb begin
    sel_we    = gnt[PORT_B] ? BWe    : AWe;
    sel_addr  = gnt[PORT_B] ? BAddr  : AAddr;
    sel_wdata = gnt[PORT_B] ? BWData : AWData;
    legal     = (sel_addr[1:0] == 2'b00) && (sel_addr <= LAST_ADDR);
  end

  // Next-state logic and memory-side outputs for fill and granted accesses.
  always_comb begin
    state_next    = state;
    fill_ptr_next = fill_ptr;
    MemAddress    = '0;
    MemWriteData  = '0;
    MemWrite      = 1'b0;
    MemRead       = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          state_next    = FILL;
          fill_ptr_next = '0;
        end
        // A grant issued alongside Start still completes this cycle.
        if (|gnt) begin
          MemAddress   = sel_addr;
          MemWriteData = sel_wdata;
          MemWrite     = legal & sel_we;
          MemRead      = legal & ~sel_we;
        end
      end
      FILL: begin
        MemWrite      = 1'b1;
        MemAddress    = fill_ptr;
        MemWriteData  = FILL_VALUE;
        fill_ptr_next = fill_ptr + 32'(WORD_BYTES);
        if (fill_ptr == LAST_ADDR) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, fill pointer and Busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fill_ptr <= '0;
      Busy     <= 1'b0;
    end else begin
      state    <= state_next;
      fill_ptr <= fill_ptr_next;
      Busy     <= (state_next == FILL);
    end
  end

  // Per-port read data, valid and error pulses, one cycle after the grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      ARData <= '0;
      AValid <= 1'b0;
      AErr   <= 1'b0;
      BRData <= '0;
      BValid <= 1'b0;
      BErr   <= 1'b0;
    end else begin
      AValid <= gnt[PORT_A] & ~AWe;
      AErr   <= gnt[PORT_A] & ~legal;
      BValid <= gnt[PORT_B] & ~BWe;
      BErr   <= gnt[PORT_B] & ~legal;
      if (gnt[PORT_A] && !AWe) ARData <= legal ? MemReadData : '0;
      if (gnt[PORT_B] && !BWe) BRData <= legal ? MemReadData : '0;
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl with a read-data scoreboard per port.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Start = 1'b0;
  logic        Busy;
  logic        AReq = 1'b0, AWe = 1'b0;
  logic [31:0] AAddr = '0, AWData = '0;
  logic        AGnt, AValid, AErr;
  logic [31:0] ARData;
  logic        BReq = 1'b0, BWe = 1'b0;
  logic [31:0] BAddr = '0, BWData = '0;
  logic        BGnt, BValid, BErr;
  logic [31:0] BRData;
  logic [31:0] MemAddress, MemWriteData, MemReadData;
  logic        MemWrite, MemRead;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  logic [31:0] mem [0:10];

  data_mem_ctrl #(.MEM_BYTES(44), .FILL_VALUE(32'd1)) dut (
    .clk(clk), .rst(rst), .Start(Start), .Busy(Busy),
    .AReq(AReq), .AWe(AWe), .AAddr(AAddr), .AWData(AWData),
    .AGnt(AGnt), .ARData(ARData), .AValid(AValid), .AErr(AErr),
    .BReq(BReq), .BWe(BWe), .BAddr(BAddr), .BWData(BWData),
    .BGnt(BGnt), .BRData(BRData), .BValid(BValid), .BErr(BErr),
    .MemAddress(MemAddress), .MemWriteData(MemWriteData),
    .MemWrite(MemWrite), .MemRead(MemRead), .MemReadData(MemReadData)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    for (int i = 0; i < 11; i++) mem[i] = 32'h1000_0000 + 32'(i);
  end

  // Memory model: combinational read, write at the rising edge.
  always @(posedge clk) begin
    if (MemWrite && (MemAddress >> 2) < 32'd11) mem[MemAddress >> 2] <= MemWriteData;
  end

  always_comb begin
    MemReadData = 32'hBAD0_BAD0;
    if ((MemAddress >> 2) < 32'd11) MemReadData = mem[MemAddress >> 2];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: each Valid pops the expected word and its due cycle.
  always @(negedge clk) begin
    exp_t e;
    if (AValid === 1'b1) begin
      if (qa.size() == 0) chk("a_valid_unexpected", 32'(AValid), 32'd0);
      else begin
        e = qa.pop_front();
        chk("a_rdata", ARData, e.data);
        chk("a_latency", 32'(cyc), 32'(e.due));
      end
    end else if (qa.size() > 0 && qa[0].due < cyc) begin
      e = qa.pop_front();
      chk("a_valid_missing", 32'(AValid), 32'd1);
    end
    if (BValid === 1'b1) begin
      if (qb.size() == 0) chk("b_valid_unexpected", 32'(BValid), 32'd0);
      else begin
        e = qb.pop_front();
        chk("b_rdata", BRData, e.data);
        chk("b_latency", 32'(cyc), 32'(e.due));
      end
    end else if (qb.size() > 0 && qb[0].due < cyc) begin
      e = qb.pop_front();
      chk("b_valid_missing", 32'(BValid), 32'd1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);

    // Reset state, with both ports requesting reads from the first free cycle.
    rst = 1'b0;
    AReq = 1'b1; AWe = 1'b0; AAddr = 32'd0;
    BReq = 1'b1; BWe = 1'b0; BAddr = 32'd4;
    #1;
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_avalid", 32'(AValid), 32'd0);
    chk("rst_bvalid", 32'(BValid), 32'd0);
    chk("rst_aerr", 32'(AErr), 32'd0);
    chk("rst_berr", 32'(BErr), 32'd0);
    chk("rst_ardata", ARData, 32'd0);
    chk("rst_brdata", BRData, 32'd0);

    // Contention: A, B, A, B.
    for (int i = 0; i < 4; i++) begin
      if (i != 0) begin
        @(negedge clk); #1;
      end
      chk("cont_agnt", 32'(AGnt), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("cont_bgnt", 32'(BGnt), (i % 2 == 0) ? 32'd0 : 32'd1);
      chk("cont_memread", 32'(MemRead), 32'd1);
      chk("cont_addr", MemAddress, (i % 2 == 0) ? 32'd0 : 32'd4);
      if (i % 2 == 0) qa.push_back('{32'h1000_0000, cyc + 1});
      else            qb.push_back('{32'h1000_0001, cyc + 1});
    end

    // Fill; B starts requesting in fill cycle 3 and must wait.
    @(negedge clk);
    AReq = 1'b0; BReq = 1'b0; Start = 1'b1;
    #1;
    chk("start_no_gnt", 32'({AGnt, BGnt}), 32'd0);
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      Start = 1'b0;
      if (k == 2) begin
        BReq = 1'b1; BWe = 1'b0; BAddr = 32'd40;
      end
      #1;
      chk("fill_busy", 32'(Busy), 32'd1);
      chk("fill_memwrite", 32'(MemWrite), 32'd1);
      chk("fill_addr", MemAddress, 32'(4 * k));
      chk("fill_data", MemWriteData, 32'd1);
      if (k >= 2) chk("fill_bgnt_blocked", 32'(BGnt), 32'd0);
    end
    @(negedge clk); #1;
    chk("fill_done_busy", 32'(Busy), 32'd0);
    chk("fill_b_first_idle_gnt", 32'(BGnt), 32'd1);
    chk("fill_b_read_addr", MemAddress, 32'd40);
    chk("fill_b_memread", 32'(MemRead), 32'd1);
    qb.push_back('{32'd1, cyc + 1});

    // Port A write then read of address 8, back to back.
    @(negedge clk);
    BReq = 1'b0;
    AReq = 1'b1; AWe = 1'b1; AAddr = 32'd8; AWData = 32'hDEADBEEF;
    #1;
    chk("aw_gnt", 32'(AGnt), 32'd1);
    chk("aw_memwrite", 32'(MemWrite), 32'd1);
    chk("aw_memread", 32'(MemRead), 32'd0);
    chk("aw_addr", MemAddress, 32'd8);
    chk("aw_data", MemWriteData, 32'hDEADBEEF);
    @(negedge clk);
    AWe = 1'b0;
    #1;
    chk("ar_gnt", 32'(AGnt), 32'd1);
    chk("ar_memread", 32'(MemRead), 32'd1);
    chk("ar_memwrite", 32'(MemWrite), 32'd0);
    qa.push_back('{32'hDEADBEEF, cyc + 1});

    // Illegal accesses: A reads 6, B writes 44.
    @(negedge clk);
    AAddr = 32'd6;
    #1;
    chk("ill_a_gnt", 32'(AGnt), 32'd1);
    chk("ill_a_memread", 32'(MemRead), 32'd0);
    chk("ill_a_memwrite", 32'(MemWrite), 32'd0);
    qa.push_back('{32'd0, cyc + 1});
    @(negedge clk);
    AReq = 1'b0;
    BReq = 1'b1; BWe = 1'b1; BAddr = 32'd44; BWData = 32'h5555_5555;
    #1;
    chk("ill_a_err", 32'(AErr), 32'd1);
    chk("ill_b_gnt", 32'(BGnt), 32'd1);
    chk("ill_b_memwrite", 32'(MemWrite), 32'd0);
    chk("ill_b_memread", 32'(MemRead), 32'd0);
    @(negedge clk);
    BWe = 1'b0; BAddr = 32'd8;
    #1;
    chk("ill_b_err", 32'(BErr), 32'd1);
    chk("ill_a_err_pulse", 32'(AErr), 32'd0);
    chk("b_read8_gnt", 32'(BGnt), 32'd1);
    qb.push_back('{32'hDEADBEEF, cyc + 1});
    @(negedge clk);
    BReq = 1'b0;
    #1;
    chk("b_read8_no_err", 32'(BErr), 32'd0);

    // Reset in fill cycle 5, then a full restart from address 0.
    @(negedge clk);
    Start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      Start = 1'b0;
      if (k == 4) rst = 1'b1;
      #1;
      chk("rf_addr", MemAddress, 32'(4 * k));
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rf_busy_cleared", 32'(Busy), 32'd0);
    chk("rf_memwrite_idle", 32'(MemWrite), 32'd0);
    chk("rf_addr_idle", MemAddress, 32'd0);
    @(negedge clk);
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    #1;
    chk("rf_restart_busy", 32'(Busy), 32'd1);
    chk("rf_restart_addr", MemAddress, 32'd0);
    chk("rf_restart_memwrite", 32'(MemWrite), 32'd1);
    repeat (11) @(negedge clk);
    #1;
    chk("rf_restart_done", 32'(Busy), 32'd0);

    repeat (2) @(negedge clk);
    #1;
    chk("a_queue_drained", 32'(qa.size()), 32'd0);
    chk("b_queue_drained", 32'(qb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
